// File: rtl/wb_arbiter_pkg.sv
// Shared types and the round-robin pick function for the 4-master Wishbone arbiter.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    TO_ERR = 2'd2
  } wb_arb_state_e;

  typedef logic [1:0] wb_arb_idx_t;

  // First asserted request at or after ptr, scanning upward and wrapping mod 4.
  function automatic wb_arb_idx_t rr_next(input logic [3:0] req, input wb_arb_idx_t ptr);
    wb_arb_idx_t idx;
    wb_arb_idx_t cand;
    logic        found;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + wb_arb_idx_t'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone B4 signal bundle with master/slave views.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;

  modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_rr_sel.sv
// Combinational round-robin selector: 4 requests, 2-bit start pointer.
module wb_arb_rr_sel
  import wb_arbiter_pkg::*;
(
  input  logic [3:0]  req,
  input  wb_arb_idx_t ptr,
  output logic        valid,
  output wb_arb_idx_t idx
);

  assign valid = |req;
  assign idx   = rr_next(req, ptr);

endmodule

// File: rtl/wb_arbiter_4x1_rr.sv
// Four Wishbone masters share one downstream port; grants last a whole CYC and a
// per-grant watchdog aborts stalled accesses with ERR.
module wb_arbiter_4x1_rr
  import wb_arbiter_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic  clk,
  input logic  rstn,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.slave  m2,
  wb_if.slave  m3,
  wb_if.master s0
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0]   adr;
    logic [WB_DATA_WIDTH-1:0]   dat_w;
    logic [WB_DATA_WIDTH/8-1:0] sel;
    logic                       we;
    logic                       cyc;
    logic                       stb;
    logic [2:0]                 cti;
    logic [1:0]                 bte;
  } m_req_t;

  wb_arb_state_e   state, state_n;
  wb_arb_idx_t     gnt, gnt_n;
  wb_arb_idx_t     rr_ptr, rr_ptr_n;
  logic [WD_W-1:0] wdog, wdog_n;

  m_req_t      m_req [4];
  m_req_t      bus;
  logic [3:0]  req;
  logic [3:0]  ack_v;
  logic [3:0]  err_v;
  logic        stall;
  logic        sel_valid;
  wb_arb_idx_t sel_idx;
  wb_arb_idx_t sel_ptr;

  assign m_req[0] = {m0.adr, m0.dat_w, m0.sel, m0.we, m0.cyc, m0.stb, m0.cti, m0.bte};
  assign m_req[1] = {m1.adr, m1.dat_w, m1.sel, m1.we, m1.cyc, m1.stb, m1.cti, m1.bte};
  assign m_req[2] = {m2.adr, m2.dat_w, m2.sel, m2.we, m2.cyc, m2.stb, m2.cti, m2.bte};
  assign m_req[3] = {m3.adr, m3.dat_w, m3.sel, m3.we, m3.cyc, m3.stb, m3.cti, m3.bte};
  assign req      = {m3.cyc, m2.cyc, m1.cyc, m0.cyc};

  // On release the scan starts just past the outgoing master, which is also the new rr_ptr.
  assign sel_ptr = (state == GRANT) ? wb_arb_idx_t'(gnt + 2'd1) : rr_ptr;

  wb_arb_rr_sel u_sel (
    .req   (req),
    .ptr   (sel_ptr),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_comb begin
    // NOTE: every output gets a default first so no branch of the case infers a latch.
    state_n  = state;
    gnt_n    = gnt;
    rr_ptr_n = rr_ptr;
    wdog_n   = '0;
    bus      = '0;
    ack_v    = '0;
    err_v    = '0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          gnt_n   = sel_idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        bus        = m_req[gnt];
        ack_v[gnt] = s0.ack;
        err_v[gnt] = s0.err;
        stall      = bus.cyc & bus.stb & ~s0.ack & ~s0.err;
        if (!req[gnt]) begin
          rr_ptr_n = sel_ptr;
          if (sel_valid) gnt_n = sel_idx;
          else           state_n = IDLE;
        end else if (stall) begin
          wdog_n = (wdog == WD_MAX) ? wdog : wdog + 1'b1;
          if (WD_EN && (wdog >= WD_LAST)) state_n = TO_ERR;
        end
      end
      TO_ERR: begin
        // Slave cycle is aborted and any coincident ACK is swallowed.
        err_v[gnt] = 1'b1;
        state_n    = GRANT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (!rstn) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      rr_ptr <= rr_ptr_n;
      wdog   <= wdog_n;
    end
  end

  assign {s0.adr, s0.dat_w, s0.sel, s0.we, s0.cyc, s0.stb, s0.cti, s0.bte} = bus;

  assign m0.ack   = ack_v[0];
  assign m1.ack   = ack_v[1];
  assign m2.ack   = ack_v[2];
  assign m3.ack   = ack_v[3];
  assign m0.err   = err_v[0];
  assign m1.err   = err_v[1];
  assign m2.err   = err_v[2];
  assign m3.err   = err_v[3];
  assign m0.dat_r = s0.dat_r;
  assign m1.dat_r = s0.dat_r;
  assign m2.dat_r = s0.dat_r;
  assign m3.dat_r = s0.dat_r;

endmodule
